// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC path: sequencer state encoding and default resolution.
`default_nettype none

package adc_pkg;

  localparam int ADC_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    SETTLE = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_dac.sv
// PWM DAC: free-running counter, duty register and magnitude compare driving the RC filter.
`default_nettype none

module pwm_dac
  import adc_pkg::*;
#(
  parameter int WIDTH = ADC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_pwm,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
    end else begin
      if (i_load) begin
        r_duty <= i_duty;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Strobe on the last count of a period, so the next edge starts a fresh one.
  assign o_wrap = &r_cnt;
  assign o_pwm  = (r_cnt < r_duty);

endmodule

`default_nettype wire

// File: rtl/sar_sequencer.sv
// Successive-approximation controller: trials one bit per step MSB first, settling the PWM DAC
// for a fixed number of periods before sampling the synchronized comparator.
`default_nettype none

module sar_sequencer
  import adc_pkg::*;
#(
  parameter int WIDTH          = ADC_WIDTH,
  parameter int SETTLE_PERIODS = 2
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             compare,
  output logic             pwm_out,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam logic [WIDTH-1:0] MSB_MASK    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_PERIODS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sync;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_settle;

  logic             w_cmp_s;
  logic             w_wrap;
  logic             w_clear;
  logic             w_load;
  logic             w_in_conv;
  logic [WIDTH-1:0] w_trial_set;
  logic [WIDTH-1:0] w_work_dec;
  logic [WIDTH-1:0] w_mask_shift;

  assign w_cmp_s      = r_sync[1];
  assign w_trial_set  = r_work | r_mask;
  assign w_work_dec   = w_cmp_s ? w_trial_set : (w_trial_set & ~r_mask);
  assign w_mask_shift = r_mask >> 1;

  pwm_dac #(
    .WIDTH (WIDTH)
  ) u_pwm_dac (
    .clk     (CLOCK_50),
    .rst     (rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_duty  (w_trial_set),
    .o_pwm   (pwm_out),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sync  <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], compare};
    end
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE:   if (start) w_next = SET;
      SET: begin
        w_next  = SETTLE;
        w_clear = 1'b1;
        w_load  = 1'b1;
      end
      SETTLE: if (w_wrap && (r_settle == SETTLE_LAST)) w_next = DECIDE;
      DECIDE: w_next = (w_mask_shift == '0) ? DONE : SET;
      DONE:   w_next = cont ? SET : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
    end else if (r_state == SET) begin
      r_settle <= '0;
    end else if ((r_state == SETTLE) && w_wrap) begin
      r_settle <= r_settle + 8'd1;
    end
  end

  // Work/mask are re-armed in IDLE and on the final DECIDE, so DONE can chain straight into SET.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_work   <= '0;
      r_mask   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_work <= '0;
          r_mask <= MSB_MASK;
        end
        DECIDE: begin
          if (w_mask_shift == '0) begin
            r_result <= w_work_dec;
            r_work   <= '0;
            r_mask   <= MSB_MASK;
          end else begin
            r_work <= w_work_dec;
            r_mask <= w_mask_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_in_conv = (r_state == SET) || (r_state == SETTLE) || (r_state == DECIDE);
  assign trial     = w_in_conv ? w_trial_set : r_result;
  assign busy      = (r_state != IDLE);
  assign valid     = (r_state == DONE);
  assign result    = r_result;

endmodule

`default_nettype wire

// File: doc/sar_sequencer.md
# sar_sequencer

Successive-approximation conversion controller for the PWM-DAC/comparator ADC path on the DE-board. It owns the PWM DAC and sequences one trial bit at a time, MSB first. For each bit it waits a fixed number of PWM periods for the external RC filter to settle, then samples the comparator and keeps or clears the bit. The finished code goes to the BCD/seven-segment display path; the in-progress trial code drives the green LEDs.

## Interface
- WIDTH, 8: conversion and PWM resolution in bits; PWM period is 2^WIDTH cycles.
- SETTLE_PERIODS, 2: full PWM periods waited per trial bit before sampling; valid range is 1..255.
- CLOCK_50  in  1  system clock; the single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level or pulse; sampled only in IDLE.
- cont  in  1  continuous mode; when 1 at DONE, the next conversion starts without returning to IDLE.
- compare  in  1  raw asynchronous comparator; 1 means Vin is at or above Vdac.
- pwm_out  out  WIDTH-independent 1  PWM DAC output to the RC filter.
- trial  out  WIDTH  code currently applied to the DAC.
- busy  out  1  high from SET of the first bit through DONE.
- result  out  WIDTH  last completed conversion; held until the next DONE.
- valid  out  1  one-cycle pulse; high during DONE.

## Operation
- compare passes through a two-flop synchronizer to give cmp_s. Only cmp_s is used.
- States and transitions:
  - IDLE → SET when start = 1.
  - SET → SETTLE.
  - SETTLE → DECIDE.
  - DECIDE → SET if bits remain, otherwise → DONE.
  - DONE → SET if cont = 1, otherwise → IDLE.
- SET:
  - Sets the current bit: trial = work | mask, where mask starts at 1 << (WIDTH-1).
  - Loads duty = trial and clears the PWM counter to 0. This restart may truncate the previous pulse, which is acceptable.
  - Clears the settle counter.
- SETTLE: lasts exactly SETTLE_PERIODS × 2^WIDTH cycles, counted on PWM counter wraps.
- DECIDE:
  - If cmp_s = 1, work = trial (bit kept); otherwise work = trial with the mask bit cleared.
  - Then mask shifts right by 1. When mask becomes 0, go to DONE.
- DONE: result = work (registered on entry), valid = 1, work and mask are re-initialised.
- IDLE: trial = result, so the DAC tracks the last value.
- PWM: pwm_out = (pwm_cnt < duty). pwm_cnt is WIDTH bits and free-running with wrap-around. duty = 0 gives constant 0; duty = 2^WIDTH − 1 gives high for all but 1 cycle per period.
- Simultaneous and boundary cases:
  - start while busy is ignored.
  - cont dropped mid-conversion takes effect only at DONE.
  - With cont = 1, valid pulses once per conversion.
- Reset, including mid-conversion, asynchronously forces IDLE and clears all of: pwm_out, trial, busy, result, valid, duty, pwm_cnt, work, mask and the synchronizer.

## Timing
- Reset values: pwm_out 0, trial 0, busy 0, result 0, valid 0.
- Per bit: 1 (SET) + SETTLE_PERIODS·2^WIDTH (SETTLE) + 1 (DECIDE) cycles.
- Latency: with start sampled in IDLE at cycle 0, valid is high at cycle L = WIDTH·(SETTLE_PERIODS·2^WIDTH + 2) + 1. With the defaults, L = 4113.
- Continuous mode: valid-to-valid spacing is L cycles.
- busy rises the cycle after start is sampled. It falls the cycle after DONE when cont = 0.
- The comparator input must be stable for at least 2 cycles before DECIDE, which SETTLE guarantees.

## Structure
- Shared package adc_pkg holds the state enum (IDLE, SET, SETTLE, DECIDE, DONE) and the default WIDTH constant.
- One sub-module, pwm_dac:
  - Contains the counter, the duty register, and the compare.
  - Inputs: clear and load; output: wrap strobe.
- sar_sequencer contains the FSM, the settle counter, the synchronizer and the work/mask registers.

## Test plan
- Reset: assert rst mid-simulation → all outputs 0 in the same cycle; pwm_out stays 0 while rst = 1.
- Single conversion: model compare = (trial ≤ 0xA5), pulse start → trial steps 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; result = 0xA5; valid is one cycle exactly 4113 cycles after start.
- Boundaries:
  - Vin code 0x00 → result 0x00.
  - Vin code 0xFF → result 0xFF.
  - With WIDTH = 4, SETTLE_PERIODS = 1, Vin 0x9 → result 0x9 at L = 73.
- Continuous mode: cont = 1 and Vin changing 0x40 → 0x3C after the first valid → results 0x40 then 0x3C; busy never drops; valid pulses 4113 cycles apart.
- Abuse:
  - start re-pulsed during bit 3 → ignored; result unchanged.
  - rst during bit 3 → IDLE with result 0; a new start converts correctly.
- PWM duty: trial = 0x80 → pwm_out high for exactly 128 of each 256 cycles during SETTLE; trial = 0x00 → never high.
